// File: rtl/conway_pattern_loader.sv
`default_nettype none
// ============================================================================
// Module   : conway_pattern_loader
// Purpose  : Upstream feeder for the conway core. Parses a byte stream
//            (count N, then N {row, col} pairs) into single-cycle cell load
//            writes while the core is held in load mode. It then switches
//            the core to run mode and counts generations via next_gen. It
//            returns to load mode after RUN_GENS generations (0 = run until
//            abort).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-low reset
//   in_data    in   stream byte
//   in_valid   in   in_data valid
//   in_ready   out  loader accepts a byte this cycle
//   abort      in   force return to idle from any state
//   next_gen   in   one-cycle pulse from the core per completed generation
//   state      out  to core: 0 = load, 1 = run
//   addr       out  to core: cell to set, {row, col}
//   load_we    out  to core: addr valid this cycle
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse when a run completes (not on abort)
//   gen_count  out  generations elapsed in the current run
// ============================================================================
module conway_pattern_loader #(
  parameter int COORD_W   = 8,
  parameter int RUN_GENS  = 4,
  parameter int GEN_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   abort,
  input  logic                   next_gen,
  output logic                   state,
  output logic [2*COORD_W-1:0]   addr,
  output logic                   load_we,
  output logic                   busy,
  output logic                   done,
  output logic [GEN_CNT_W-1:0]   gen_count
);

  localparam logic [GEN_CNT_W-1:0] RUN_TARGET = GEN_CNT_W'(RUN_GENS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ROW   = 3'd1,
    S_COL   = 3'd2,
    S_FLUSH = 3'd3,
    S_RUN   = 3'd4
  } fsm_t;

  fsm_t               fsm;
  logic [7:0]         remaining;
  logic [COORD_W-1:0] row;
  logic               accept;
  logic [GEN_CNT_W-1:0] gen_next;

  assign accept = in_valid && in_ready;

  // Saturating increment of the generation counter.
  always_comb begin
    gen_next = gen_count;
    if (gen_count != '1) begin
      gen_next = gen_count + GEN_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm       <= S_IDLE;
      remaining <= '0;
      row       <= '0;
      in_ready  <= 1'b0;
      state     <= 1'b0;
      addr      <= '0;
      load_we   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      gen_count <= '0;
    end else begin
      // Strobes default low; addr and gen_count hold unless updated.
      load_we <= 1'b0;
      done    <= 1'b0;
      if (abort) begin
        // Drop any partial frame; in_ready stays low for one cycle.
        fsm      <= S_IDLE;
        state    <= 1'b0;
        in_ready <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (fsm)
          S_IDLE: begin
            in_ready <= 1'b1;
            if (accept) begin
              busy <= 1'b1;
              if (in_data == 8'd0) begin
                fsm      <= S_FLUSH;
                in_ready <= 1'b0;
              end else begin
                remaining <= in_data;
                fsm       <= S_ROW;
              end
            end
          end
          S_ROW: begin
            if (accept) begin
              row <= in_data[COORD_W-1:0];
              fsm <= S_COL;
            end
          end
          S_COL: begin
            if (accept) begin
              addr      <= {row, in_data[COORD_W-1:0]};
              load_we   <= 1'b1;
              remaining <= remaining - 8'd1;
              if (remaining == 8'd1) begin
                fsm      <= S_FLUSH;
                in_ready <= 1'b0;
              end else begin
                fsm <= S_ROW;
              end
            end
          end
          S_FLUSH: begin
            // The final load_we is on the bus during this cycle with state=0.
            fsm       <= S_RUN;
            gen_count <= '0;
          end
          S_RUN: begin
            if (!state) begin
              // First RUN cycle arms run mode; next_gen is not counted
              // until the core has actually been switched to run.
              state <= 1'b1;
            end else if (next_gen) begin
              gen_count <= gen_next;
              if ((RUN_GENS != 0) && (gen_next == RUN_TARGET)) begin
                fsm      <= S_IDLE;
                state    <= 1'b0;
                done     <= 1'b1;
                busy     <= 1'b0;
                in_ready <= 1'b1;
              end
            end
          end
          default: begin
            fsm      <= S_IDLE;
            state    <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conway_pattern_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_conway_pattern_loader
// Purpose  : Self-checking bench for conway_pattern_loader. Instance dut uses
//            RUN_GENS=4 and instance dut_z uses RUN_GENS=0. Expected cell
//            addresses come from a frame parser model working on byte queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conway_pattern_loader;

  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid, abort, next_gen;
  logic        in_ready, state, load_we, busy, done;
  logic [15:0] addr, gen_count;

  logic [7:0]  in_data_z;
  logic        in_valid_z, abort_z, next_gen_z;
  logic        in_ready_z, state_z, load_we_z, busy_z, done_z;
  logic [15:0] addr_z, gen_count_z;

  conway_pattern_loader #(.COORD_W(CW), .RUN_GENS(4), .GEN_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .next_gen(next_gen), .state(state),
    .addr(addr), .load_we(load_we), .busy(busy), .done(done),
    .gen_count(gen_count)
  );

  conway_pattern_loader #(.COORD_W(CW), .RUN_GENS(0), .GEN_CNT_W(16)) dut_z (
    .clk(clk), .rst(rst), .in_data(in_data_z), .in_valid(in_valid_z),
    .in_ready(in_ready_z), .abort(abort_z), .next_gen(next_gen_z),
    .state(state_z), .addr(addr_z), .load_we(load_we_z), .busy(busy_z),
    .done(done_z), .gen_count(gen_count_z)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  frame_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          bad_we = 0;
  int          done_z_cnt = 0;

  // Observe the core-facing bus mid-cycle.
  always @(negedge clk) begin
    if (load_we) begin
      got_q.push_back(addr);
      if (state) bad_we++;
    end
    if (done_z) done_z_cnt++;
  end

  // Reference: count byte N then N (row, col) pairs -> N cell addresses.
  function automatic void build_expected();
    int n;
    logic [7:0] r, c;
    exp_q.delete();
    n = int'(frame_q[0]);
    for (int i = 0; i < n; i++) begin
      r = frame_q[1 + 2 * i];
      c = frame_q[2 + 2 * i];
      exp_q.push_back({r[CW-1:0], c[CW-1:0]});
    end
  endfunction

  // Called just after a negedge; returns just after the negedge that follows
  // the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int maxgap);
    foreach (frame_q[i]) send_byte(frame_q[i], int'($urandom_range(0, maxgap)));
  endtask

  task automatic pulse_gen(input int gap);
    repeat (gap) @(negedge clk);
    next_gen = 1'b1;
    @(negedge clk);
    next_gen = 1'b0;
  endtask

  // After the last byte of a frame: state stays 0 one more cycle, then 1.
  task automatic check_load(input string name);
    checks++;
    if (state !== 1'b0) begin errors++; $display("FAIL %s_state_k1: got %0b required 0", name, state); end
    @(negedge clk);
    checks++;
    if (state !== 1'b0) begin errors++; $display("FAIL %s_state_k2: got %0b required 0", name, state); end
    @(negedge clk);
    checks++;
    if (state !== 1'b1) begin errors++; $display("FAIL %s_state_run: got %0b required 1", name, state); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_we_count: got %0d required %0d", name, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_addr%0d: got %h required %h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (gen_count !== 16'd0) begin errors++; $display("FAIL %s_gen_zero: got %0d required 0", name, gen_count); end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; abort = 1'b0; next_gen = 1'b0;
    in_data_z = 8'h00; in_valid_z = 1'b0; abort_z = 1'b0; next_gen_z = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({state, load_we, in_ready, busy, done} !== 5'b0 || addr !== 16'h0 || gen_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got st=%0b we=%0b rdy=%0b busy=%0b done=%0b addr=%h gen=%0d required all 0",
               state, load_we, in_ready, busy, done, addr, gen_count);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_ready: got rdy=%0b busy=%0b required rdy=1 busy=0", in_ready, busy);
    end
  endtask

  task automatic test_glider();
    frame_q = '{8'h05, 8'h02, 8'hFF, 8'h01, 8'hFD, 8'h02, 8'hFD, 8'h03, 8'hFD, 8'h03, 8'hFE};
    build_expected();
    got_q.delete();
    send_frame(0);
    check_load("glider");
  endtask

  task automatic test_gen_count();
    for (int g = 1; g <= 4; g++) begin
      pulse_gen(int'($urandom_range(0, 3)));
      checks++;
      if (gen_count !== 16'(g)) begin errors++; $display("FAIL gen_count_%0d: got %0d required %0d", g, gen_count, g); end
      checks++;
      if (g < 4 && (state !== 1'b1 || done !== 1'b0 || busy !== 1'b1)) begin
        errors++; $display("FAIL gen_running_%0d: got st=%0b done=%0b busy=%0b required 1 0 1", g, state, done, busy);
      end else if (g == 4 && (state !== 1'b0 || done !== 1'b1 || busy !== 1'b0)) begin
        errors++; $display("FAIL gen_complete: got st=%0b done=%0b busy=%0b required 0 1 0", state, done, busy);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL gen_after_done: got done=%0b rdy=%0b required 0 1", done, in_ready);
    end
  endtask

  task automatic test_backpressure();
    frame_q = '{8'h05, 8'h02, 8'hFF, 8'h01, 8'hFD, 8'h02, 8'hFD, 8'h03, 8'hFD, 8'h03, 8'hFE};
    build_expected();
    got_q.delete();
    send_frame(3);
    check_load("gaps");
    repeat (4) pulse_gen(int'($urandom_range(0, 2)));
  endtask

  task automatic test_random_frames();
    int n;
    for (int f = 0; f < 3; f++) begin
      n = int'($urandom_range(1, 6));
      frame_q.delete();
      frame_q.push_back(8'(n));
      for (int i = 0; i < 2 * n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
      build_expected();
      got_q.delete();
      send_frame(2);
      check_load($sformatf("rand%0d", f));
      repeat (4) pulse_gen(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_empty_frame();
    frame_q = '{8'h00};
    build_expected();
    got_q.delete();
    send_frame(0);
    check_load("empty");
    repeat (4) pulse_gen(1);
  endtask

  task automatic test_abort_mid_load();
    frame_q = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(1);
    checks++;
    if (gen_count !== 16'd4) begin errors++; $display("FAIL abort_gen_before: got %0d required 4", gen_count); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({state, load_we, in_ready, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL abort_idle: got st=%0b we=%0b rdy=%0b busy=%0b done=%0b required all 0",
               state, load_we, in_ready, busy, done);
    end
    checks++;
    if (gen_count !== 16'd4) begin errors++; $display("FAIL abort_gen_hold: got %0d required 4", gen_count); end
    frame_q = '{8'h01, 8'h10, 8'h20};
    build_expected();
    got_q.delete();
    send_frame(0);
    check_load("abort_new");
  endtask

  task automatic test_reset_mid_run();
    pulse_gen(0);
    pulse_gen(2);
    checks++;
    if (gen_count !== 16'd2) begin errors++; $display("FAIL rst_gen_before: got %0d required 2", gen_count); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (state !== 1'b0 || gen_count !== 16'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got st=%0b gen=%0d busy=%0b rdy=%0b required 0 0 0 0", state, gen_count, busy, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_run_forever();
    int n;
    in_data_z  = 8'h00;
    in_valid_z = 1'b1;
    n = 0;
    while (!in_ready_z && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin errors++; $display("FAIL z_send_timeout: in_ready=%0b required 1", in_ready_z); end
    @(negedge clk);
    in_valid_z = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 12; g++) begin
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
      next_gen_z = 1'b1;
      @(negedge clk);
      next_gen_z = 1'b0;
    end
    checks++;
    if (gen_count_z !== 16'd12 || state_z !== 1'b1 || busy_z !== 1'b1) begin
      errors++;
      $display("FAIL z_persist: got gen=%0d st=%0b busy=%0b required 12 1 1", gen_count_z, state_z, busy_z);
    end
    checks++;
    if (done_z_cnt != 0) begin errors++; $display("FAIL z_no_done: got %0d done pulses required 0", done_z_cnt); end
    abort_z = 1'b1;
    @(negedge clk);
    abort_z = 1'b0;
    checks++;
    if (state_z !== 1'b0 || busy_z !== 1'b0 || in_ready_z !== 1'b0 || done_z !== 1'b0 || gen_count_z !== 16'd12) begin
      errors++;
      $display("FAIL z_abort: got st=%0b busy=%0b rdy=%0b done=%0b gen=%0d required 0 0 0 0 12",
               state_z, busy_z, in_ready_z, done_z, gen_count_z);
    end
  endtask

  initial begin
    test_reset();
    test_glider();
    test_gen_count();
    test_backpressure();
    test_random_frames();
    test_empty_frame();
    test_abort_mid_load();
    test_reset_mid_run();
    test_run_forever();
    checks++;
    if (bad_we != 0) begin errors++; $display("FAIL we_in_run: got %0d load_we cycles with state=1 required 0", bad_we); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conway_pattern_loader.md
Name: conway_pattern_loader

Overview:
Upstream feeder for the conway core. Accepts a byte stream describing a seed pattern, converts it into per-cell load writes (addr + load_we) while holding the core in load mode, then switches the core to run mode. In run mode it counts generations via the core's next_gen pulse and returns to load mode after a programmed number of generations or an abort.

Parameters:
COORD_W, 8, bits per coordinate; addr = {row, col}, width 2*COORD_W
RUN_GENS, 4, generations to run before returning to idle; 0 = run until abort
GEN_CNT_W, 16, width of the generation counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts byte this cycle
abort  in  1  force return to idle from any state
next_gen  in  1  single-cycle pulse from core per completed generation
state  out  1  to core: 0 = load, 1 = run
addr  out  2*COORD_W  to core: cell to set, {row, col}
load_we  out  1  to core: addr valid this cycle; core sets cell only when high
busy  out  1  high in any state except IDLE
done  out  1  single-cycle pulse when run completes (not on abort)
gen_count  out  GEN_CNT_W  generations elapsed in current run

Behaviour:
- All outputs registered. Reset (rst low, async) → IDLE; state=0, addr=0, load_we=0, in_ready=0, busy=0, done=0, gen_count=0.
- Handshake: byte consumed on rising edge where in_valid && in_ready. in_valid may drop between bytes; loader waits indefinitely. One byte per cycle sustained.
- Frame format: count byte N (0..255), then N pairs (row byte, col byte). Only low COORD_W bits of each coordinate byte used.
- FSM states: IDLE, ROW, COL, FLUSH, RUN.
  - IDLE: in_ready=1. On count byte: N=0 → FLUSH; else latch remaining=N → ROW.
  - ROW: in_ready=1. On byte: latch row → COL.
  - COL: in_ready=1. On byte: addr<={row, byte}, load_we<=1 for exactly one cycle; remaining-1; remaining becomes 0 → FLUSH, else → ROW.
  - FLUSH: in_ready=0; one cycle, guarantees final load_we is seen with state=0. Then state<=1, gen_count<=0 → RUN.
  - RUN: in_ready=0, state=1. Each next_gen pulse increments gen_count (saturating at all-ones). If RUN_GENS≠0 and the pulse makes gen_count==RUN_GENS: state<=0, done<=1 one cycle → IDLE. RUN_GENS=0: stay until abort.
- load_we low in every cycle not immediately following a col handshake; addr holds last value when load_we low.
- Latency: col byte accepted at edge k → load_we/addr high in cycle k..k+1. Last col at edge k → state=1 from edge k+2.
- next_gen ignored outside RUN. next_gen in the same cycle as FLUSH→RUN transition ignored.
- abort (sampled synchronously, priority over all other events): next edge → IDLE, state=0, load_we=0, in_ready=0 for that cycle, no done pulse; gen_count holds last value. Partially received frame discarded; next accepted byte is a new count byte.
- busy = (fsm != IDLE).
- Reset asserted mid-load or mid-run: immediate return to reset values; core returns to load mode.

Test Plan:
- Glider load, RUN_GENS=4: bytes 05,02,FF,01,FD,02,FD,03,FD,03,FE back-to-back → five single-cycle load_we with addr 02FF,01FD,02FD,03FD,03FE in order; state=1 two cycles after last byte accepted; no load_we while state=1.
- Generation count: in RUN, pulse next_gen 4 times with gaps → gen_count 1,2,3,4; on 4th, state=0 and done high exactly one cycle; busy low; in_ready high next cycle.
- Backpressure/gaps: same glider stream with in_valid low random 0–3 cycles between bytes → identical addr sequence; no extra or missing load_we.
- Empty frame: byte 00 → no load_we; state=1 two cycles after acceptance.
- Abort mid-load: abort after 2 of 5 pairs → IDLE next edge, state=0, no done; new frame 01,10,20 → single load_we addr 1020, then run.
- Reset mid-run: rst low during RUN with gen_count=2 → state=0, gen_count=0, busy=0 immediately (asynchronous); RUN_GENS=0 run persists >10 next_gen pulses until abort.
